// File: rtl/bg_pattern_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bg_pkg                                                     |
// | Brief   : Shared mode encoding and colour constants, RGB332 format.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bg_pkg;

  typedef enum logic [1:0] {
    BG_OFF    = 2'd0,
    BG_STATIC = 2'd1,
    BG_SCROLL = 2'd2,
    BG_BLINK  = 2'd3
  } bg_mode_t;

  localparam logic [7:0] BG_FILL    = 8'h58;
  localparam logic [7:0] BG_BORDER  = 8'hFC;
  localparam logic [7:0] BG_BRACKET = 8'hFF;
  localparam logic [7:0] BG_BLACK   = 8'h00;

endpackage
`default_nettype wire

// File: rtl/bg_pattern_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bg_pattern_gen_if                                          |
// | Brief   : Pixel-in / colour-out bundle of the background generator.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface bg_pattern_gen_if;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        modeReq;
  logic [1:0]  modeSel;
  logic [7:0]  BG_RGB;
  logic        boardersDrawReq;
  logic        modeAck;

  modport master (
    output pixelX, pixelY, startOfFrame, modeReq, modeSel,
    input  BG_RGB, boardersDrawReq, modeAck
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame, modeReq, modeSel,
    output BG_RGB, boardersDrawReq, modeAck
  );
endinterface
`default_nettype wire

// File: rtl/bg_pattern_gen_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bg_star_lfsr                                               |
// | Brief   : 16-bit Fibonacci LFSR (taps 16,14,13,11), seed load/step.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bg_star_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [15:0] state_o
);
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)
      lfsr_d = SEED;
    else if (adv_i)
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;
endmodule
`default_nettype wire

// File: rtl/bg_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bg_pattern_gen                                             |
// | Brief   : Background/bracket generator, 2-stage pixel pipeline.      |
// |           Define BG_STARFIELD_EN to compile in the LFSR starfield.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bg_pattern_gen
  import bg_pkg::*;
#(
  parameter int unsigned FRAME_W        = 635,
  parameter int unsigned FRAME_H        = 475,
  parameter int unsigned BRACKET_OFFSET = 30,
  parameter int unsigned STRIP_TOP_Y    = 9,
  parameter int unsigned STRIP_BOTTOM_Y = 23,
  parameter int unsigned STRIP_LEFT_X   = 31,
  parameter int unsigned CELL_W_LOG2    = 1,
  parameter int unsigned SCROLL_DIV     = 2,
  parameter int unsigned BLINK_FRAMES   = 30
`ifdef BG_STARFIELD_EN
  , parameter logic [15:0] STAR_SEED    = 16'hACE1
`endif
) (
  input  logic           clk,
  input  logic           resetN,
  bg_pattern_gen_if.slave bg_if
);
  localparam logic [10:0] c_frm_r   = 11'(FRAME_W);
  localparam logic [10:0] c_frm_b   = 11'(FRAME_H);
  localparam logic [10:0] c_brk_lt  = 11'(BRACKET_OFFSET);
  localparam logic [10:0] c_brk_r   = 11'(FRAME_W - BRACKET_OFFSET);
  localparam logic [10:0] c_brk_b   = 11'(FRAME_H - BRACKET_OFFSET);
  localparam logic [10:0] c_strip_t = 11'(STRIP_TOP_Y);
  localparam logic [10:0] c_strip_b = 11'(STRIP_BOTTOM_Y);
  localparam logic [10:0] c_strip_l = 11'(STRIP_LEFT_X);
  localparam logic [10:0] c_strip_e = 11'(STRIP_LEFT_X + (256 << CELL_W_LOG2));

  localparam int c_fcnt_w = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int c_bcnt_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_fcnt_w-1:0] c_fcnt_max = c_fcnt_w'(SCROLL_DIV - 1);
  localparam logic [c_bcnt_w-1:0] c_bcnt_max = c_bcnt_w'(BLINK_FRAMES - 1);

  // ---------------- frame-synchronised control state ----------------
  bg_mode_t              mode_q, mode_d, pend_q, pend_d, w_req_mode;
  logic                  pend_vld_q, pend_vld_d;
  logic [7:0]            scroll_q, scroll_d;
  logic [c_fcnt_w-1:0]   fcnt_q, fcnt_d;
  logic [c_bcnt_w-1:0]   bcnt_q, bcnt_d;
  logic                  vis_q, vis_d;
  logic                  ack_q, ack_d;

  // A request arriving with startOfFrame beats anything already pending.
  assign w_req_mode = bg_if.modeReq ? bg_mode_t'(bg_if.modeSel) : pend_q;

  always_comb begin
    mode_d     = mode_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    scroll_d   = scroll_q;
    fcnt_d     = fcnt_q;
    bcnt_d     = bcnt_q;
    vis_d      = vis_q;
    ack_d      = 1'b0;
    if (bg_if.startOfFrame) begin
      if (mode_q == BG_SCROLL) begin
        if (fcnt_q == c_fcnt_max) begin
          fcnt_d   = '0;
          scroll_d = scroll_q + 8'd1;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      if (mode_q == BG_BLINK) begin
        if (bcnt_q == c_bcnt_max) begin
          bcnt_d = '0;
          vis_d  = ~vis_q;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      if (bg_if.modeReq || pend_vld_q) begin
        mode_d = w_req_mode;
        ack_d  = 1'b1;
        if (w_req_mode == BG_BLINK && mode_q != BG_BLINK) begin
          bcnt_d = '0;
          vis_d  = 1'b1;
        end
      end
      pend_vld_d = 1'b0;
    end else if (bg_if.modeReq) begin
      pend_d     = bg_mode_t'(bg_if.modeSel);
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mode_q     <= BG_STATIC;
      pend_q     <= BG_OFF;
      pend_vld_q <= 1'b0;
      scroll_q   <= 8'd0;
      fcnt_q     <= '0;
      bcnt_q     <= '0;
      vis_q      <= 1'b1;
      ack_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      scroll_q   <= scroll_d;
      fcnt_q     <= fcnt_d;
      bcnt_q     <= bcnt_d;
      vis_q      <= vis_d;
      ack_q      <= ack_d;
    end
  end

  // ---------------- stage 1: region classification ----------------
  logic [10:0] w_x, w_y, w_xrel;
  logic [7:0]  w_off;
  logic        w_star;
  logic        s1_brk_q, s1_brk_d, s1_brd_q, s1_brd_d;
  logic        s1_strip_q, s1_strip_d, s1_star_q;
  logic [7:0]  s1_idx_q, s1_idx_d;

  assign w_x    = bg_if.pixelX;
  assign w_y    = bg_if.pixelY;
  assign w_xrel = w_x - c_strip_l;  // only meaningful once the strip test has passed
  assign w_off  = (mode_q == BG_SCROLL) ? scroll_q : 8'd0;

`ifdef BG_STARFIELD_EN
  logic [15:0] w_lfsr;

  bg_star_lfsr #(.SEED(STAR_SEED)) u_star_lfsr (
    .clk     (clk),
    .resetN  (resetN),
    .load_i  (bg_if.startOfFrame),
    .adv_i   ((w_x <= c_frm_r) && (w_y <= c_frm_b)),
    .state_o (w_lfsr)
  );

  assign w_star = (w_lfsr[15:9] == 7'd0) && (w_x <= c_frm_r) && (w_y <= c_frm_b);
`else
  assign w_star = 1'b0;
`endif

  always_comb begin
    s1_brk_d   = ((w_x == c_brk_lt) || (w_y == c_brk_lt) || (w_x == c_brk_r) || (w_y == c_brk_b))
                 && ((mode_q != BG_BLINK) || vis_q);
    s1_brd_d   = (w_x == 11'd0) || (w_y == 11'd0) || (w_x == c_frm_r) || (w_y == c_frm_b);
    s1_strip_d = (w_y >= c_strip_t) && (w_y <= c_strip_b) && (w_x >= c_strip_l) && (w_x < c_strip_e);
    s1_idx_d   = 8'(w_xrel >> CELL_W_LOG2) + w_off;
  end

  // ---------------- stage 2: colour priority ----------------
  logic [7:0] rgb_q, rgb_d;
  logic       drq_q, drq_d;

  always_comb begin
    rgb_d = BG_FILL;
    drq_d = 1'b0;
    if (mode_q == BG_OFF) begin
      rgb_d = BG_BLACK;
    end else if (s1_brk_q) begin
      rgb_d = BG_BRACKET;
      drq_d = 1'b1;
    end else if (s1_brd_q) begin
      rgb_d = BG_BORDER;
    end else if (s1_strip_q) begin
      rgb_d = s1_idx_q;
    end else if (s1_star_q) begin
      rgb_d = BG_BRACKET;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_brk_q   <= 1'b0;
      s1_brd_q   <= 1'b0;
      s1_strip_q <= 1'b0;
      s1_star_q  <= 1'b0;
      s1_idx_q   <= 8'd0;
      rgb_q      <= BG_BLACK;
      drq_q      <= 1'b0;
    end else begin
      s1_brk_q   <= s1_brk_d;
      s1_brd_q   <= s1_brd_d;
      s1_strip_q <= s1_strip_d;
      s1_star_q  <= w_star;
      s1_idx_q   <= s1_idx_d;
      rgb_q      <= rgb_d;
      drq_q      <= drq_d;
    end
  end

  assign bg_if.BG_RGB          = rgb_q;
  assign bg_if.boardersDrawReq = drq_q;
  assign bg_if.modeAck         = ack_q;
endmodule
`default_nettype wire
